// File: rtl/mm_copr_pkg.sv
// Shared definitions for the memory-mapped coprocessor datapath.
// Holds the front-end stage state encoding and the default bus widths.
// No logic; imported by mm_input_streamer and mm_prefetch_fifo.
package mm_copr_pkg;

   localparam int MM_ADDR_W = 10;
   localparam int MM_DATA_W = 32;

   // Input streamer FSM encoding (fixed values, shared with the front-end FSM)
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ARM     = 2'd1;
   localparam logic [1:0] STREAM  = 2'd2;
   localparam logic [1:0] DRAINED = 2'd3;

endpackage

// File: rtl/mm_prefetch_fifo.sv
// 2-entry prefetch FIFO holding words read from the input memory.
// Latency: a push is visible at the head on the edge after it is written; head is a register.
// Backpressure: none internally; the caller never pushes when full nor pops when empty.
// Ports: i_clk, i_rst_n (sync, active-low), i_flush (sync clear, wins over push/pop),
//        i_push/i_push_dat (tail write), i_pop (advance head), o_occ (0..2), o_head_dat.
module mm_prefetch_fifo
   import mm_copr_pkg::*;
#(
   parameter int DATA_W = MM_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_flush,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_dat,
   input  logic              i_pop,
   output logic [1:0]        o_occ,
   output logic [DATA_W-1:0] o_head_dat
);

   logic [DATA_W-1:0] r_mem [0:1];
   logic              r_rd_ptr;
   logic              r_wr_ptr;
   logic [1:0]        r_occ;

   always_ff @(posedge i_clk) begin
      // Entries are cleared as well so the head reads 0 after reset/flush
      if (!i_rst_n || i_flush) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_occ    <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (i_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({i_push, i_pop})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_occ      = r_occ;
   assign o_head_dat = r_mem[r_rd_ptr];

endmodule

// File: rtl/mm_input_streamer.sv
// Streams size words from a synchronous input memory into a 2-entry prefetch buffer.
// Latency: start -> ARM -> STREAM (mem_en) -> word lands one edge after issue -> rdy next cycle.
// Backpressure: reads stop while buffer+in-flight would exceed 2; en/rden gate pop and issue.
// Ports: aclk/aresetn (sync, active-low), start/size/base_addr (run setup), en/rden/send
//        (front-end strobes), mem_en/mem_addr/mem_rdata (input memory), rdy/done/out_data/out_send.
// Optional: define MM_INPUT_STREAMER_STALL_CNT_EN to add stall_cnt[31:0] (STREAM cycles with rdy=0).
module mm_input_streamer
   import mm_copr_pkg::*;
#(
   parameter int ADDR_W = MM_ADDR_W,
   parameter int DATA_W = MM_DATA_W,
   parameter int SIZE_W = ADDR_W + 1
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              start,
   input  logic [SIZE_W-1:0] size,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              en,
   input  logic              rden,
   input  logic              send,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rdy,
   output logic              done,
   output logic [DATA_W-1:0] out_data,
   output logic              out_send
`ifdef MM_INPUT_STREAMER_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   logic [1:0]        r_state;
   logic              r_done;
   logic [SIZE_W-1:0] r_size;
   logic [ADDR_W-1:0] r_base;
   logic [SIZE_W-1:0] r_issued;
   logic [SIZE_W-1:0] r_consumed;
   logic              r_inflight;

   logic [1:0]        w_state_nxt;
   logic              w_in_stream;
   logic              w_rdy;
   logic              w_pop;
   logic              w_flush;
   logic [1:0]        w_occ;
   logic [1:0]        w_occ_after;
   logic              w_room;
   logic              w_mem_en;
   logic [DATA_W-1:0] w_head;

   assign w_in_stream = (r_state == STREAM);
   assign w_rdy       = w_in_stream && (w_occ != 2'd0);
   assign w_pop       = en && w_rdy;
   assign w_flush     = !start;

   // Slots committed after this cycle: the head being popped now frees its slot,
   // which lets a read issue every cycle while the consumer keeps up.
   assign w_occ_after = w_occ - {1'b0, w_pop} + {1'b0, r_inflight};
   assign w_room      = (w_occ_after < 2'd2);

   assign w_mem_en = w_in_stream && rden && (r_issued < r_size) && w_room;
   assign mem_en   = w_mem_en;
   // Address wraps modulo 2^ADDR_W by truncation
   assign mem_addr = r_base + ADDR_W'(r_issued);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = ARM;
         ARM:     w_state_nxt = (r_size == '0) ? DRAINED : STREAM;
         STREAM:  if (r_consumed == r_size) w_state_nxt = DRAINED;
         DRAINED: w_state_nxt = DRAINED;
         default: w_state_nxt = IDLE;
      endcase
      // Dropping start aborts from any state
      if (!start) w_state_nxt = IDLE;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state    <= IDLE;
         r_done     <= 1'b0;
         r_size     <= '0;
         r_base     <= '0;
         r_issued   <= '0;
         r_consumed <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (w_state_nxt == DRAINED);
         if (!start) begin
            // Abort: any read still in flight is dropped, its data never lands
            r_issued   <= '0;
            r_consumed <= '0;
            r_inflight <= 1'b0;
         end else begin
            if (r_state == IDLE) begin
               r_size     <= size;
               r_base     <= base_addr;
               r_issued   <= '0;
               r_consumed <= '0;
            end else begin
               if (w_mem_en) r_issued <= r_issued + SIZE_W'(1);
               if (w_pop)    r_consumed <= r_consumed + SIZE_W'(1);
            end
            r_inflight <= w_mem_en;
         end
      end
   end

   // Memory data is valid the cycle after issue and goes straight into the tail
   mm_prefetch_fifo #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .i_clk      (aclk),
      .i_rst_n    (aresetn),
      .i_flush    (w_flush),
      .i_push     (r_inflight),
      .i_push_dat (mem_rdata),
      .i_pop      (w_pop),
      .o_occ      (w_occ),
      .o_head_dat (w_head)
   );

   assign rdy      = w_rdy;
   assign done     = r_done;
   assign out_data = w_head;
   assign out_send = send && w_rdy;

`ifdef MM_INPUT_STREAMER_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_stall_cnt <= '0;
      end else if ((w_state_nxt == ARM) && (r_state != ARM)) begin
         r_stall_cnt <= '0;
      end else if (w_in_stream && !w_rdy && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mm_input_streamer.sv
// Directed bench for mm_input_streamer with a synchronous memory model and
// address/data scoreboards filled when a run is programmed.
module tb_mm_input_streamer;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int SW = AW + 1;

   logic          clk = 1'b0;
   logic          aresetn;
   logic          start;
   logic [SW-1:0] size;
   logic [AW-1:0] base_addr;
   logic          en;
   logic          rden;
   logic          send;
   logic          mem_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata;
   logic          rdy;
   logic          done;
   logic [DW-1:0] out_data;
   logic          out_send;
`ifdef MM_INPUT_STREAMER_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_issue  = 0;
   int n_pop    = 0;
   int last_pop_cyc = 0;

   logic [AW-1:0] q_addr[$];
   logic [DW-1:0] q_data[$];

   mm_input_streamer dut (
      .aclk      (clk),
      .aresetn   (aresetn),
      .start     (start),
      .size      (size),
      .base_addr (base_addr),
      .en        (en),
      .rden      (rden),
      .send      (send),
      .mem_en    (mem_en),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .rdy       (rdy),
      .done      (done),
      .out_data  (out_data),
      .out_send  (out_send)
`ifdef MM_INPUT_STREAMER_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
      return {6'h2A, a, 6'h15, ~a};
   endfunction

   // Synchronous memory: data one cycle after the read enable
   always @(posedge clk) begin
      if (mem_en) mem_rdata <= mem_val(mem_addr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [AW-1:0] b, input int sz);
      logic [AW-1:0] a;
      base_addr = b;
      size      = SW'(sz);
      for (int i = 0; i < sz; i++) begin
         a = b + AW'(i);
         q_addr.push_back(a);
         q_data.push_back(mem_val(a));
      end
   endtask

   task automatic clear_sb();
      q_addr.delete();
      q_data.delete();
   endtask

   task automatic wait_done(input string tag, input int lim);
      int k;
      k = 0;
      while (!done && k < lim) begin
         tick();
         k++;
      end
      chk({tag, "_done"}, done, 1'b1);
   endtask

   // Monitor: every issued read and every pop is checked against the scoreboard
   always @(negedge clk) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      if (mem_en) begin
         n_issue++;
         chk("read_pending", 32'(q_addr.size() > 0), 1);
         if (q_addr.size() > 0) begin
            ea = q_addr.pop_front();
            chk("read_addr", 32'(mem_addr), 32'(ea));
         end
      end
      if (en && rdy) begin
         n_pop++;
         last_pop_cyc = cyc;
         chk("pop_pending", 32'(q_data.size() > 0), 1);
         if (q_data.size() > 0) begin
            ed = q_data.pop_front();
            chk("pop_data", out_data, ed);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] v;
      aresetn = 1'b0; start = 1'b0; size = '0; base_addr = '0;
      en = 1'b0; rden = 1'b0; send = 1'b0;
      tick(); tick();
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_rdy", rdy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_out_send", out_send, 1'b0);
      chk("rst_out_data", out_data, 0);
      aresetn = 1'b1;
      tick();

      // Run 1: size 4 from 0x3F0, consumer always ready
      n_issue = 0; n_pop = 0;
      load(10'h3F0, 4);
      rden = 1'b1; en = 1'b1; send = 1'b1; start = 1'b1;
      tick();
      chk("arm_mem_en", mem_en, 1'b0);
      chk("arm_done", done, 1'b0);
`ifdef MM_INPUT_STREAMER_STALL_CNT_EN
      chk("arm_stall_cnt", stall_cnt, 0);
`endif
      v = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         v[i] = mem_en;
         if (i == 1) chk("r1_rdy_empty", rdy, 1'b0);
         if (i == 2) begin
            chk("r1_rdy_first", rdy, 1'b1);
            chk("r1_out_send", out_send, 1'b1);
`ifdef MM_INPUT_STREAMER_STALL_CNT_EN
            chk("r1_stall_cnt", stall_cnt, 2);
`endif
         end
      end
      chk("r1_consecutive_reads", 32'(v), 32'hF);
      wait_done("r1", 20);
      chk("r1_done_latency", cyc - last_pop_cyc, 2);
      chk("r1_reads", n_issue, 4);
      chk("r1_pops", n_pop, 4);
      chk("r1_rdy_drained", rdy, 1'b0);
      chk("r1_out_send_drained", out_send, 1'b0);
      start = 1'b0;
      tick();
      chk("r1_done_cleared", done, 1'b0);

      // Run 2: size 0 goes straight to DRAINED
      n_issue = 0;
      load(10'h055, 0);
      start = 1'b1;
      tick();
      chk("r2_arm_done", done, 1'b0);
      tick();
      chk("r2_done_2nd_edge", done, 1'b1);
      tick(); tick();
      chk("r2_no_reads", n_issue, 0);
      start = 1'b0;
      tick();

      // Run 3: address wrap at the top of memory
      n_issue = 0; n_pop = 0;
      load(10'h3FE, 4);
      start = 1'b1;
      wait_done("r3", 30);
      chk("r3_reads", n_issue, 4);
      chk("r3_sb_empty", q_data.size(), 0);
      start = 1'b0;
      tick();

      // Run 4: consumer stalled, buffer fills, one pop releases one read
      n_issue = 0; n_pop = 0;
      load(10'h010, 8);
      en = 1'b0; start = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      chk("r4_reads_stalled", n_issue, 2);
      chk("r4_mem_en_stalled", mem_en, 1'b0);
      chk("r4_rdy_full", rdy, 1'b1);
      en = 1'b1;
      tick();
      en = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("r4_reads_after_pulse", n_issue, 3);
      chk("r4_pops", n_pop, 1);
      start = 1'b0;
      tick();
      clear_sb();

      // Run 5: abort with one word buffered and one in flight, then restart
      n_issue = 0;
      load(10'h020, 3);
      start = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("r5_pre_rdy", rdy, 1'b1);
      chk("r5_pre_reads", n_issue, 2);
      start = 1'b0;
      tick();
      chk("r5_abort_rdy", rdy, 1'b0);
      chk("r5_abort_done", done, 1'b0);
      chk("r5_abort_out_data", out_data, 0);
      chk("r5_abort_addr", 32'(mem_addr), 32'h020);
      clear_sb();
      tick();
      n_issue = 0; n_pop = 0;
      load(10'h020, 3);
      en = 1'b1; start = 1'b1;
      tick(); tick();
      chk("r5_restart_mem_en", mem_en, 1'b1);
      chk("r5_restart_addr", 32'(mem_addr), 32'h020);
      wait_done("r5", 30);
      chk("r5_reads", n_issue, 3);
      chk("r5_pops", n_pop, 3);
      start = 1'b0;
      tick();

      // Run 6: reset pulse in the middle of streaming
      load(10'h100, 8);
      start = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      aresetn = 1'b0;
      tick();
      start = 1'b0;
      clear_sb();
      chk("r6_mem_en", mem_en, 1'b0);
      chk("r6_mem_addr", 32'(mem_addr), 0);
      chk("r6_rdy", rdy, 1'b0);
      chk("r6_done", done, 1'b0);
      chk("r6_out_send", out_send, 1'b0);
      chk("r6_out_data", out_data, 0);
`ifdef MM_INPUT_STREAMER_STALL_CNT_EN
      chk("r6_stall_cnt", stall_cnt, 0);
`endif
      aresetn = 1'b1;
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
